// File: rtl/apb_pkg.sv
// Shared constants for the APB request master: default widths/timeout,
// FSM state encoding and the timeout counter width helper.
package apb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_req_master_if.sv
// Bundle of the command/response handshake and the APB bus signals.
// "master" is the view of the request master, "slave" the view of the
// environment (command source, response sink and APB completer).
interface apb_req_master_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts consecutive ACCESS cycles without PREADY. expire is asserted in the
// cycle that would make the count reach TIMEOUT, so the FSM can abort then.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_timeout_cnt: TIMEOUT must be within 2..255");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear has priority; count only stalled ACCESS cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LAST);

endmodule

// File: rtl/apb_req_master.sv
// Single-outstanding APB requester: takes one command, runs SETUP/ACCESS on
// the bus (with a wait-state timeout) and holds the response until taken.
// Every APB and response output comes straight from a flop.
module apb_req_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_req_master_if.master bus
);

  logic [1:0]        state_q,       state_d;
  logic              psel_q,        psel_d;
  logic              penable_q,     penable_d;
  logic              pwrite_q,      pwrite_d;
  logic [ADDR_W-1:0] paddr_q,       paddr_d;
  logic [DATA_W-1:0] pwdata_q,      pwdata_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic              rsp_err_q,     rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expire;

  // SETUP always precedes ACCESS, so clearing there starts every ACCESS at 0.
  assign cnt_clear  = (state_q == ST_SETUP);
  assign cnt_enable = (state_q == ST_ACCESS) && !bus.PREADY;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expire  (cnt_expire)
  );

  // Next-state and next-output logic; address/control/wdata only change on accept.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus.req_write;
          paddr_d   = bus.req_addr;
          pwdata_d  = bus.req_wdata;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // A completion in the expiring cycle wins over the timeout.
        if (bus.PREADY) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
        end else if (cnt_expire) begin
          state_d       = ST_RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= ST_IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: command driver, APB completer model and a
// response monitor working off a scoreboard queue of expected responses.
module tb_apb_req_master;

  localparam int TMO = 16;

  logic PCLK;
  logic PRESETn;

  apb_req_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_req_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;   // completer read data when it finally answers
    int          waits;   // wait states before PREADY (>= TMO: never answers in time)
    bit          slverr;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          tmo;
    int          rsp_cyc; // cycle in which rsp_valid must first appear
  } exp_t;

  cmd_t plan_q[$];
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  int   stall_once = -1;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: outcome of one command from its wait states alone.
  function automatic bit is_timeout(input int waits);
    return waits >= TMO;
  endfunction

  function automatic int access_cycles(input int waits);
    return is_timeout(waits) ? TMO : waits + 1;
  endfunction

  function automatic exp_t expect_of(input cmd_t c, input int acc_cyc);
    exp_t e;
    if (is_timeout(c.waits)) begin
      e.rdata = 32'd0;
      e.err   = 1'b1;
      e.tmo   = 1'b1;
    end else begin
      e.rdata = c.write ? 32'd0 : c.rdata;
      e.err   = c.slverr;
      e.tmo   = 1'b0;
    end
    // accept cycle, one SETUP cycle, the ACCESS cycles, then RESP
    e.rsp_cyc = acc_cyc + 2 + access_cycles(c.waits);
    return e;
  endfunction

  function automatic cmd_t mk(input bit w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int waits, input bit se);
    cmd_t c;
    c.write = w; c.addr = a; c.wdata = wd; c.rdata = rd; c.waits = waits; c.slverr = se;
    return c;
  endfunction

  // Call just after a negedge. Junk payload is driven while not ready.
  task automatic send(input cmd_t c, output int acc);
    int guard;
    guard = 0;
    plan_q.push_back(c);
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && guard < 200) begin
      bus.req_write = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      @(negedge PCLK);
      guard++;
    end
    chk("req_accept", bus.req_ready, 1);
    bus.req_write = c.write;
    bus.req_addr  = c.addr;
    bus.req_wdata = c.wdata;
    acc = cyc;
    exp_q.push_back(expect_of(c, acc));
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge PCLK);
      guard++;
    end
    chk("drain_complete", exp_q.size(), 0);
  endtask

  // APB completer model
  initial begin : completer
    cmd_t        cur;
    int          phase;
    int          acc;
    bit          last_write;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    phase = 0; acc = 0; last_write = 0; last_addr = 0; last_wdata = 0;
    cur = mk(0, 0, 0, 0, 0, 0);
    bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESETn !== 1'b1) begin
        phase = 0; last_write = 0; last_addr = 0; last_wdata = 0;
        bus.PREADY = 1'b0;
        continue;
      end
      if (bus.PSEL && !bus.PENABLE) begin
        chk("setup_single_cycle", phase, 0);
        chk("setup_cmd_pending", plan_q.size() != 0, 1);
        if (plan_q.size() != 0) cur = plan_q.pop_front();
        chk("setup_ctrl", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {cur.write, cur.addr, cur.wdata});
        phase = 1;
        acc   = 0;
        bus.PREADY = 1'($urandom); bus.PRDATA = $urandom; bus.PSLVERR = 1'($urandom);
      end else if (bus.PSEL && bus.PENABLE) begin
        chk("access_after_setup", phase != 0, 1);
        phase = 2;
        acc++;
        chk("access_ctrl_stable", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {cur.write, cur.addr, cur.wdata});
        if (acc == cur.waits + 1) begin
          bus.PREADY = 1'b1; bus.PRDATA = cur.rdata; bus.PSLVERR = cur.slverr;
        end else begin
          bus.PREADY = 1'b0; bus.PRDATA = $urandom; bus.PSLVERR = 1'($urandom);
        end
      end else begin
        chk("penable_without_psel", bus.PENABLE, 0);
        if (phase == 2) begin
          chk("access_cycles", acc, access_cycles(cur.waits));
          last_write = cur.write; last_addr = cur.addr; last_wdata = cur.wdata;
        end
        phase = 0;
        chk("idle_hold", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {last_write, last_addr, last_wdata});
        bus.PREADY = 1'($urandom); bus.PRDATA = $urandom; bus.PSLVERR = 1'($urandom);
      end
    end
  end

  // Response monitor / scoreboard
  initial begin : monitor
    bit   seen;
    int   stall_left;
    exp_t e;
    seen = 0; stall_left = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge PCLK);
      if (PRESETn !== 1'b1) begin
        seen = 0; stall_left = 0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (exp_q.size() == 0) begin
        chk("rsp_valid_spurious", bus.rsp_valid, 0);
        bus.rsp_ready = 1'($urandom);
      end else if (bus.rsp_valid) begin
        e = exp_q[0];
        chk("req_ready_in_resp", bus.req_ready, 0);
        chk("rsp_payload", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, {e.rdata, e.err, e.tmo});
        if (!seen) begin
          seen = 1;
          chk("rsp_latency", cyc, e.rsp_cyc);
          if (stall_once >= 0) begin
            stall_left = stall_once;
            stall_once = -1;
          end else begin
            stall_left = rand_ready ? int'($urandom_range(0, 3)) : 0;
          end
        end
        bus.rsp_ready = (stall_left == 0);
        if (stall_left == 0) begin
          $display("RSP cyc=%0d rdata=0x%08h err=%0b timeout=%0b", cyc,
                   bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
          void'(exp_q.pop_front());
          seen = 0;
        end else begin
          stall_left--;
        end
      end else begin
        bus.rsp_ready = 1'($urandom);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // Main stimulus
  initial begin : driver
    int   a0, a1, a2, a3, g;
    cmd_t c;
    PRESETn = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_psel",        bus.PSEL,        0);
    chk("rst_penable",     bus.PENABLE,     0);
    chk("rst_pwrite",      bus.PWRITE,      0);
    chk("rst_paddr",       bus.PADDR,       0);
    chk("rst_pwdata",      bus.PWDATA,      0);
    chk("rst_rsp_valid",   bus.rsp_valid,   0);
    chk("rst_rsp_rdata",   bus.rsp_rdata,   0);
    chk("rst_rsp_err",     bus.rsp_err,     0);
    chk("rst_rsp_timeout", bus.rsp_timeout, 0);
    #2 PRESETn = 1'b1;
    #1 chk("req_ready_after_rst", bus.req_ready, 1);
    @(negedge PCLK);

    // Directed: zero-wait write, 3-wait read, slave error, timeout and its edge
    send(mk(1, 32'h004, 32'h0ABC, 32'hDEAD_BEEF, 0, 0), a0); drain();
    send(mk(0, 32'h000, 32'h5555, 32'h0000_0123, 3, 0), a0); drain();
    send(mk(0, 32'h010, 32'h0, 32'hCAFE_0001, 1, 1), a0); drain();
    send(mk(1, 32'h020, 32'h1234, 32'h0, 1000, 0), a0); drain();
    send(mk(0, 32'h024, 32'h0, 32'h0BAD_F00D, TMO - 1, 0), a0); drain();

    // Backpressure then back-to-back
    rand_ready = 1'b0;
    stall_once = 5;
    send(mk(0, 32'h100, 32'h0, 32'h1111_1111, 0, 0), a0);
    send(mk(1, 32'h104, 32'h2222, 32'h0, 0, 0), a1);
    send(mk(0, 32'h108, 32'h0, 32'h3333_3333, 0, 1), a2);
    send(mk(1, 32'h10C, 32'h4444, 32'h0, 0, 0), a3);
    chk("b2b_gap_after_stall", a1 - a0, 9);
    chk("b2b_gap_2", a2 - a1, 4);
    chk("b2b_gap_3", a3 - a2, 4);
    drain();

    // Reset in the middle of ACCESS
    send(mk(0, 32'h040, 32'h0, 32'h7777_7777, 10, 0), a0);
    g = 0;
    while (!(bus.PSEL && bus.PENABLE) && g < 20) begin
      @(negedge PCLK);
      g++;
    end
    chk("reached_access", bus.PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_rst_psel",    bus.PSEL,    0);
    chk("async_rst_penable", bus.PENABLE, 0);
    plan_q.delete();
    exp_q.delete();
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    #1 chk("req_ready_after_mid_rst", bus.req_ready, 1);
    repeat (20) @(negedge PCLK);
    send(mk(1, 32'h044, 32'hABCD, 32'h0, 2, 0), a0); drain();

    // Randomized traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      c.write  = 1'($urandom);
      c.addr   = $urandom & 32'hFFFF_FFFC;
      c.wdata  = $urandom;
      c.rdata  = $urandom;
      c.slverr = ($urandom_range(0, 3) == 0);
      c.waits  = (r < 5) ? 0 :
                 (r < 8) ? int'($urandom_range(1, 4)) :
                 (r == 8) ? int'($urandom_range(TMO - 2, TMO - 1)) :
                            int'($urandom_range(TMO, TMO + 2));
      send(c, a0);
      repeat ($urandom_range(0, 2)) @(negedge PCLK);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
